ifm_bank_scheduler: RTL and testbench

//  Owns the multi-bank (ping-pong by default) IFM memory between two conv/pool layers.

---
 rtl/ifm_bank_scheduler_pkg.sv | 18 +
 rtl/ifm_bank_scheduler_if.sv | 45 ++++
 rtl/ifm_bank_scheduler_bank_ring_ptr.sv | 23 ++
 rtl/ifm_bank_scheduler.sv | 94 +++++++++
 tb/tb_ifm_bank_scheduler.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/ifm_bank_scheduler_pkg.sv
// Shared types and width helpers for the IFM bank scheduler.
// Consumer FSM encoding and bank-select/occupancy width derivation.
package ifm_bank_scheduler_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } cu_state_t;

  function automatic int bank_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_bits(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ifm_bank_scheduler_if.sv
// Producer/consumer handshake bundle around the IFM bank ring.
// master drives the layer-side pulses, slave is the scheduler.
interface ifm_bank_scheduler_if #(
  parameter int NUM_BANKS = 2
) ();
  import ifm_bank_scheduler_pkg::*;

  localparam int BANK_BITS = bank_bits(NUM_BANKS);
  localparam int CNT_BITS  = cnt_bits(NUM_BANKS);

  logic                 start_from_previous;
  logic                 end_from_next;
  logic                 consumer_ready;
  logic [BANK_BITS-1:0] wr_bank_sel;
  logic [BANK_BITS-1:0] rd_bank_sel;
  logic                 start_to_next;
  logic                 producer_ready;
  logic [CNT_BITS-1:0]  bank_count;
  logic                 error;

  modport master (
    output start_from_previous,
    output end_from_next,
    output consumer_ready,
    input  wr_bank_sel,
    input  rd_bank_sel,
    input  start_to_next,
    input  producer_ready,
    input  bank_count,
    input  error
  );

  modport slave (
    input  start_from_previous,
    input  end_from_next,
    input  consumer_ready,
    output wr_bank_sel,
    output rd_bank_sel,
    output start_to_next,
    output producer_ready,
    output bank_count,
    output error
  );

endinterface

// File: rtl/ifm_bank_scheduler_bank_ring_ptr.sv
// Mod-N ring pointer with advance enable.
// Wraps N-1 -> 0 explicitly so non-power-of-2 rings never overrun.
module bank_ring_ptr #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         adv,
  output logic [W-1:0] ptr
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (ptr == LAST) ? '0 : ptr + W'(1);
    end
  end

endmodule

// File: rtl/ifm_bank_scheduler.sv
// Ring scheduler for the IFM banks between two conv/pool layers.
// Tracks occupancy, launches the consumer, flags protocol misuse.
module ifm_bank_scheduler
  import ifm_bank_scheduler_pkg::*;
#(
  parameter int NUM_BANKS = 2
) (
  input logic                 clk,
  input logic                 reset,
  ifm_bank_scheduler_if.slave bus
);

  localparam int BANK_BITS = bank_bits(NUM_BANKS);
  localparam int CNT_BITS  = cnt_bits(NUM_BANKS);
  localparam logic [CNT_BITS-1:0] FULL = CNT_BITS'(NUM_BANKS);

  cu_state_t            state;
  cu_state_t            state_nxt;
  logic                 start_q;
  logic                 start_nxt;
  logic                 err_q;
  logic [CNT_BITS-1:0]  count;
  logic [BANK_BITS-1:0] wr_ptr;
  logic [BANK_BITS-1:0] rd_ptr;
  logic                 full;
  logic                 accept;
  logic                 reject;
  logic                 rel;
  logic                 stray;

  // Fullness is judged on the pre-edge count, even if a bank frees now.
  assign full   = (count == FULL);
  assign accept = bus.start_from_previous && !full;
  assign reject = bus.start_from_previous && full;
  assign rel    = (state == S_BUSY) && bus.end_from_next;
  assign stray  = (state == S_IDLE) && bus.end_from_next;

  bank_ring_ptr #(.N(NUM_BANKS), .W(BANK_BITS)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .adv   (accept),
    .ptr   (wr_ptr)
  );

  bank_ring_ptr #(.N(NUM_BANKS), .W(BANK_BITS)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .adv   (rel),
    .ptr   (rd_ptr)
  );

  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (count != '0 && bus.consumer_ready) begin
          start_nxt = 1'b1;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (rel) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      count   <= '0;
    end else begin
      state   <= state_nxt;
      start_q <= start_nxt;
      err_q   <= err_q | reject | stray;
      unique case ({accept, rel})
        2'b10:   count <= count + CNT_BITS'(1);
        2'b01:   count <= count - CNT_BITS'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.wr_bank_sel    = wr_ptr;
  assign bus.rd_bank_sel    = rd_ptr;
  assign bus.start_to_next  = start_q;
  assign bus.producer_ready = !full;
  assign bus.bank_count     = count;
  assign bus.error          = err_q;

endmodule

// File: tb/tb_ifm_bank_scheduler.sv
// Directed bench for ifm_bank_scheduler: 2-bank and 3-bank rings.
// Inputs change #1 after posedge; outputs sampled at the same point.
module tb_ifm_bank_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  ifm_bank_scheduler_if #(.NUM_BANKS(2)) b2 ();
  ifm_bank_scheduler_if #(.NUM_BANKS(3)) b3 ();

  ifm_bank_scheduler #(.NUM_BANKS(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2)
  );

  ifm_bank_scheduler #(.NUM_BANKS(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (b3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    int exp_rd [6];
    exp_rd = '{0, 1, 2, 0, 1, 2};

    b2.start_from_previous = 1'b0;
    b2.end_from_next       = 1'b0;
    b2.consumer_ready      = 1'b0;
    b3.start_from_previous = 1'b0;
    b3.end_from_next       = 1'b0;
    b3.consumer_ready      = 1'b0;

    // 1: reset held 3 cycles under random inputs
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b2.start_from_previous = 1'($urandom_range(0, 1));
      b2.end_from_next       = 1'($urandom_range(0, 1));
      b2.consumer_ready      = 1'($urandom_range(0, 1));
      step();
    end
    chk("rst_wr",   32'(b2.wr_bank_sel), 0);
    chk("rst_rd",   32'(b2.rd_bank_sel), 0);
    chk("rst_start", 32'(b2.start_to_next), 0);
    chk("rst_prdy", 32'(b2.producer_ready), 1);
    chk("rst_cnt",  32'(b2.bank_count), 0);
    chk("rst_err",  32'(b2.error), 0);
    b2.start_from_previous = 1'b0;
    b2.end_from_next       = 1'b0;
    b2.consumer_ready      = 1'b0;
    reset = 1'b1;

    // 2: single pass
    b2.consumer_ready = 1'b1;
    b2.start_from_previous = 1'b1;
    step();
    b2.start_from_previous = 1'b0;
    chk("sp_cnt1",  32'(b2.bank_count), 1);
    chk("sp_wr1",   32'(b2.wr_bank_sel), 1);
    chk("sp_nost",  32'(b2.start_to_next), 0);
    step();
    chk("sp_start", 32'(b2.start_to_next), 1);
    chk("sp_rd0",   32'(b2.rd_bank_sel), 0);
    step();
    chk("sp_pulse", 32'(b2.start_to_next), 0);
    b2.end_from_next = 1'b1;
    step();
    b2.end_from_next = 1'b0;
    chk("sp_cnt0",  32'(b2.bank_count), 0);
    chk("sp_rd1",   32'(b2.rd_bank_sel), 1);
    chk("sp_err",   32'(b2.error), 0);
    step();
    chk("sp_idle",  32'(b2.start_to_next), 0);

    // 3: fill both banks, then overflow
    b2.consumer_ready = 1'b0;
    do_reset();
    b2.start_from_previous = 1'b1;
    step();
    step();
    b2.start_from_previous = 1'b0;
    chk("full_cnt",  32'(b2.bank_count), 2);
    chk("full_prdy", 32'(b2.producer_ready), 0);
    chk("full_err0", 32'(b2.error), 0);
    b2.start_from_previous = 1'b1;
    step();
    b2.start_from_previous = 1'b0;
    chk("ovf_err",  32'(b2.error), 1);
    chk("ovf_cnt",  32'(b2.bank_count), 2);
    chk("ovf_wr",   32'(b2.wr_bank_sel), 0);
    b2.consumer_ready = 1'b1;
    step();
    b2.consumer_ready = 1'b0;
    chk("ovf_launch", 32'(b2.start_to_next), 1);
    // full on pre-edge count: this start is refused though a bank frees
    b2.start_from_previous = 1'b1;
    b2.end_from_next       = 1'b1;
    step();
    b2.start_from_previous = 1'b0;
    b2.end_from_next       = 1'b0;
    chk("prefull_cnt", 32'(b2.bank_count), 1);
    chk("prefull_wr",  32'(b2.wr_bank_sel), 0);
    chk("prefull_rd",  32'(b2.rd_bank_sel), 1);
    chk("prefull_prdy", 32'(b2.producer_ready), 1);

    // 4: simultaneous accept and release
    do_reset();
    b2.consumer_ready = 1'b1;
    b2.start_from_previous = 1'b1;
    step();
    b2.start_from_previous = 1'b0;
    step();
    chk("sim_launch", 32'(b2.start_to_next), 1);
    b2.start_from_previous = 1'b1;
    b2.end_from_next       = 1'b1;
    step();
    b2.start_from_previous = 1'b0;
    b2.end_from_next       = 1'b0;
    chk("sim_cnt",   32'(b2.bank_count), 1);
    chk("sim_wr",    32'(b2.wr_bank_sel), 0);
    chk("sim_rd",    32'(b2.rd_bank_sel), 1);
    chk("sim_gap",   32'(b2.start_to_next), 0);
    step();
    chk("sim_next",  32'(b2.start_to_next), 1);
    chk("sim_bank1", 32'(b2.rd_bank_sel), 1);
    b2.consumer_ready = 1'b0;
    b2.end_from_next  = 1'b1;
    step();
    b2.end_from_next  = 1'b0;
    chk("sim_done",  32'(b2.bank_count), 0);
    chk("sim_err",   32'(b2.error), 0);

    // 5: end while idle
    b2.end_from_next = 1'b1;
    step();
    b2.end_from_next = 1'b0;
    chk("proto_err", 32'(b2.error), 1);
    chk("proto_rd",  32'(b2.rd_bank_sel), 0);
    chk("proto_cnt", 32'(b2.bank_count), 0);
    step();
    step();
    chk("proto_sticky", 32'(b2.error), 1);
    do_reset();
    chk("proto_clr", 32'(b2.error), 0);

    // 6: 3-bank ring rounds
    b3.consumer_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b3.start_from_previous = 1'b1;
      step();
      b3.start_from_previous = 1'b0;
      step();
      chk($sformatf("r3_start%0d", i), 32'(b3.start_to_next), 1);
      chk($sformatf("r3_rd%0d", i),    32'(b3.rd_bank_sel), exp_rd[i]);
      b3.end_from_next = 1'b1;
      step();
      b3.end_from_next = 1'b0;
      chk($sformatf("r3_cnt%0d", i),   32'(b3.bank_count), 0);
    end
    chk("r3_wrwrap", 32'(b3.wr_bank_sel), 0);
    b3.consumer_ready = 1'b0;
    b3.start_from_previous = 1'b1;
    step();
    step();
    step();
    step();
    b3.start_from_previous = 1'b0;
    chk("r3_full",  32'(b3.bank_count), 3);
    chk("r3_prdy",  32'(b3.producer_ready), 0);
    chk("r3_wr",    32'(b3.wr_bank_sel), 0);
    chk("r3_err",   32'(b3.error), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
